regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port among NUM_REQ writeback sources (ALU, load unit, CSR).
//  Round-robin arbitration with per-requester valid/ready handshake.
//  One registered output stage drives register_file wr_en/wr_addr/wdata.
//  Optional read-bypass covers the cycle in which a committed write is not yet visible in the array.
// PARAMETERS
//  NUM_REQ         3    number of writeback requesters (>=2)
//  XLEN            32   data width (rv32i_pkg constant)
//  REG_ADDR_WIDTH  5    register address width (rv32i_pkg constant)
// PORTS
//  clk         in   1                     single clock, all state on posedge
//  rst         in   1                     reset; synchronous, active-high
//  req_valid   in   NUM_REQ               requester i has a write pending
//  req_ready   out  NUM_REQ               one-hot or zero; requester i accepted this cycle
//  req_addr    in   NUM_REQ*REG_ADDR_WIDTH  flattened; slice i = [i*5 +: 5]
//  req_data    in   NUM_REQ*XLEN          flattened; slice i = [i*XLEN +: XLEN]
//  wb_stall    in   1                     pipeline freeze; blocks all grants
//  rf_wr_en    out  1                     to register_file wr_en
//  rf_wr_addr  out  REG_ADDR_WIDTH        to register_file wr_addr
//  rf_wdata    out  XLEN                  to register_file wdata
// BEHAVIOUR
//  - Transfer on requester i when req_valid[i] && req_ready[i].
//  - Requester holds valid/addr/data stable until accepted.
//  - req_ready is combinational from req_valid, ptr, wb_stall and rst.
//  - Grant: first i with req_valid[i], scanning ptr, ptr+1, ... mod NUM_REQ. At most one grant per cycle.
//  - ptr (clog2(NUM_REQ) bits): after grant g, ptr <= (g+1) mod NUM_REQ, wrapping NUM_REQ-1 -> 0. No grant -> ptr holds.
//  - Latency: one cycle. Output register loads on every edge:
//      rf_wr_en   <= grant && addr_g != 0
//      rf_wr_addr <= addr_g
//      rf_wdata   <= data_g
//    With no grant: rf_wr_en <= 0; addr/data hold their previous values.
//  - x0 write: accepted (ready=1, ptr advances), but rf_wr_en stays 0. Acts as discard.
//  - wb_stall=1: req_ready all 0; ptr holds; rf_wr_en <= 0 next edge. A previously registered write still
//    drains, because register_file samples it at the same edge.
//  - No back-pressure from the register file: the output stage never holds a write for more than one cycle.
//  - rst=1: req_ready all 0 combinationally. Next edge: rf_wr_en=0, rf_wr_addr=0, rf_wdata=0, ptr=0.
//  - rst mid-operation: any registered, uncommitted write is dropped. Un-accepted requests stay pending at
//    their sources and are arbitrated from ptr=0 after release.
//  - Back-to-back writes to the same address from different requesters commit in grant order, one per cycle.
//    No merging.
// CONFIGURATION
//  Macro RF_WB_FORWARD_EN.
//  Defined: adds ports
//      rd_addr0, rd_addr1    in   REG_ADDR_WIDTH
//      rf_rdata0, rf_rdata1  in   XLEN   (from register_file)
//      fwd_rdata0, fwd_rdata1 out XLEN
//    fwd_rdataN = (rf_wr_en && rd_addrN != 0 && rd_addrN == rf_wr_addr) ? rf_wdata : rf_rdataN.
//    Combinational, no added latency.
//  Undefined: these ports and the bypass logic do not exist. Consumers read register_file directly and must
//    tolerate one cycle of staleness.
// TESTING
//  1. rst=1 for 2 cycles, all req_valid=1 -> req_ready=000, rf_wr_en=0.
//     Release -> first grant to req0; rf_wr_en=1 one cycle later.
//  2. All valid; addr 1/2/3, data 0xA/0xB/0xC held -> grants 0,1,2,0,...
//     rf_wr_addr 1,2,3,1 one cycle late; rf_wr_en=1 every cycle.
//  3. ptr=1, only req0 valid -> req_ready=001 same cycle; ptr becomes 1. Checks wrap.
//  4. req1 addr 0, data 0xDEAD -> req_ready[1]=1; next cycle rf_wr_en=0; ptr advances to 2.
//  5. wb_stall=1 for 3 cycles, req2 valid -> no ready; rf_wr_en=0 from 2nd cycle; ptr held.
//     Release -> req2 granted if ptr scan reaches it first.
//  6. RF_WB_FORWARD_EN: write x5=0x1234 accepted, next cycle rd_addr0=5, rf_rdata0=0 -> fwd_rdata0=0x1234.
//     rd_addr1=6, rf_rdata1=0x77 -> fwd_rdata1=0x77. Cycle after -> pass-through.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback sources.
// Define RF_WB_FORWARD_EN to add the two-port read bypass of the registered write.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*XLEN-1:0]           req_data,
  input  logic                              wb_stall,
  output logic                              rf_wr_en,
  output logic [REG_ADDR_WIDTH-1:0]         rf_wr_addr,
  output logic [XLEN-1:0]                   rf_wdata
`ifdef RF_WB_FORWARD_EN
  ,
  input  logic [REG_ADDR_WIDTH-1:0]         rd_addr0,
  input  logic [REG_ADDR_WIDTH-1:0]         rd_addr1,
  input  logic [XLEN-1:0]                   rf_rdata0,
  input  logic [XLEN-1:0]                   rf_rdata1,
  output logic [XLEN-1:0]                   fwd_rdata0,
  output logic [XLEN-1:0]                   fwd_rdata1
`endif
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic                      wr_en_q, wr_en_d;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]           wdata_q, wdata_d;

  logic                      grant_valid;
  logic [PTR_W-1:0]          grant_idx;
  logic [REG_ADDR_WIDTH-1:0] grant_addr;
  logic [XLEN-1:0]           grant_data;

  // Scan from ptr upward modulo NUM_REQ; first valid requester wins.
  always_comb begin
    int unsigned sum;
    logic [PTR_W-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = 32'(ptr_q) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = PTR_W'(sum);
      if (!grant_valid && req_valid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    if (rst || wb_stall) grant_valid = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (grant_valid) req_ready[grant_idx] = 1'b1;
  end

  assign grant_addr = req_addr[32'(grant_idx)*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
  assign grant_data = req_data[32'(grant_idx)*XLEN +: XLEN];

  always_comb begin
    int unsigned nxt;
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wdata_d   = wdata_q;
    nxt       = 32'(grant_idx) + 1;
    if (nxt >= NUM_REQ) nxt = 0;
    if (grant_valid) begin
      // x0 writes are consumed but never reach the array.
      ptr_d     = PTR_W'(nxt);
      wr_en_d   = (grant_addr != '0);
      wr_addr_d = grant_addr;
      wdata_d   = grant_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign rf_wr_en   = wr_en_q;
  assign rf_wr_addr = wr_addr_q;
  assign rf_wdata   = wdata_q;

`ifdef RF_WB_FORWARD_EN
  always_comb begin
    fwd_rdata0 = rf_rdata0;
    fwd_rdata1 = rf_rdata1;
    if (wr_en_q && rd_addr0 != '0 && rd_addr0 == wr_addr_q) fwd_rdata0 = wdata_q;
    if (wr_en_q && rd_addr1 != '0 && rd_addr1 == wr_addr_q) fwd_rdata1 = wdata_q;
  end
`endif

endmodule
